pulse_gen_multi: RTL

Multi-channel programmable pulse generator, the parametrised successor to the fixed 1 kHz LED toggler. Each of NCH channels produces a pulse train with run-time programmable period, high width and burst count, started by a per-channel trigger and stoppable at any time. It sits between the register/command front end and the driver pins, clocked from the 32 MHz system clock.

---
 rtl/pulse_gen_multi_if.sv | 28 ++
 rtl/pulse_gen_multi.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pulse_gen_multi_if.sv
// Config/trigger/output bundle for pulse_gen_multi.
// master drives config writes and TRIG/STOP; slave returns PULSE/BUSY/DONE.
interface pulse_gen_multi_if #(
  parameter int NCH   = 4,
  parameter int CNT_W = 24
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic             CFG_WE;
  logic [CH_W-1:0]  CFG_CH;
  logic [1:0]       CFG_SEL;
  logic [CNT_W-1:0] CFG_DATA;
  logic [NCH-1:0]   TRIG;
  logic [NCH-1:0]   STOP;
  logic [NCH-1:0]   PULSE;
  logic [NCH-1:0]   BUSY;
  logic [NCH-1:0]   DONE;

  modport master (
    output CFG_WE, CFG_CH, CFG_SEL, CFG_DATA, TRIG, STOP,
    input  PULSE, BUSY, DONE
  );

  modport slave (
    input  CFG_WE, CFG_CH, CFG_SEL, CFG_DATA, TRIG, STOP,
    output PULSE, BUSY, DONE
  );
endinterface

// File: rtl/pulse_gen_multi.sv
// Multi-channel programmable pulse generator: per-channel period/width/burst (and phase).
// Optional macro PULSE_GEN_PHASE_EN adds the PHASE register and the start DELAY state.
module pulse_gen_multi #(
  parameter int NCH        = 4,
  parameter int CNT_W      = 24,
  parameter int DEF_PERIOD = 31999,
  parameter int DEF_WIDTH  = 16000
) (
  input  logic              CLK,
  input  logic              RST,
  pulse_gen_multi_if.slave  bus
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DELAY = 2'd2
  } state_t;

  logic [NCH-1:0] pulse_vec;
  logic [NCH-1:0] busy_vec;
  logic [NCH-1:0] done_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic             cfg_hit;
      logic [CNT_W-1:0] period_reg, width_reg, burst_reg;
      logic [CNT_W-1:0] period_sh_reg, period_sh_next;
      logic [CNT_W-1:0] width_sh_reg, width_sh_next;
      logic [CNT_W-1:0] burst_sh_reg, burst_sh_next;
      logic [CNT_W-1:0] cnt_reg, cnt_next;
      logic [CNT_W-1:0] burst_cnt_reg, burst_cnt_next;
      logic [CNT_W:0]   burst_done_cnt;
      state_t           state_reg, state_next;
      logic             pulse_reg, pulse_next;
      logic             done_reg, done_next;
`ifdef PULSE_GEN_PHASE_EN
      logic [CNT_W-1:0] phase_reg;
      logic [CNT_W-1:0] phase_sh_reg, phase_sh_next;
`endif

      // Out-of-range channel numbers match no generate index and are dropped.
      assign cfg_hit = bus.CFG_WE && (bus.CFG_CH == CH_W'(gi));

      always_ff @(posedge CLK) begin
        if (RST) begin
          period_reg <= CNT_W'(DEF_PERIOD);
          width_reg  <= CNT_W'(DEF_WIDTH);
          burst_reg  <= '0;
`ifdef PULSE_GEN_PHASE_EN
          phase_reg  <= '0;
`endif
        end else if (cfg_hit) begin
          case (bus.CFG_SEL)
            2'd0:    period_reg <= bus.CFG_DATA;
            2'd1:    width_reg  <= bus.CFG_DATA;
            2'd2:    burst_reg  <= bus.CFG_DATA;
`ifdef PULSE_GEN_PHASE_EN
            2'd3:    phase_reg  <= bus.CFG_DATA;
`endif
            default: ;
          endcase
        end
      end

      // Periods completed including the one ending now; compared one bit wider.
      assign burst_done_cnt = {1'b0, burst_cnt_reg} + {{CNT_W{1'b0}}, 1'b1};

      always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        burst_cnt_next = burst_cnt_reg;
        period_sh_next = period_sh_reg;
        width_sh_next  = width_sh_reg;
        burst_sh_next  = burst_sh_reg;
`ifdef PULSE_GEN_PHASE_EN
        phase_sh_next  = phase_sh_reg;
`endif
        done_next      = 1'b0;
        case (state_reg)
          S_IDLE: begin
            if (bus.TRIG[gi]) begin
              period_sh_next = period_reg;
              width_sh_next  = width_reg;
              burst_sh_next  = burst_reg;
              cnt_next       = '0;
              burst_cnt_next = '0;
              state_next     = S_RUN;
`ifdef PULSE_GEN_PHASE_EN
              phase_sh_next  = phase_reg;
              if (phase_reg != '0) state_next = S_DELAY;
`endif
            end
          end
`ifdef PULSE_GEN_PHASE_EN
          S_DELAY: begin
            if (cnt_reg == phase_sh_reg - CNT_W'(1)) begin
              state_next = S_RUN;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end
`endif
          S_RUN: begin
            if (cnt_reg == period_sh_reg) begin
              // Period boundary: new config only takes effect from here.
              cnt_next       = '0;
              burst_cnt_next = burst_cnt_reg + CNT_W'(1);
              period_sh_next = period_reg;
              width_sh_next  = width_reg;
              burst_sh_next  = burst_reg;
              if ((burst_sh_reg != '0) && (burst_done_cnt >= {1'b0, burst_sh_reg})) begin
                state_next = S_IDLE;
                done_next  = 1'b1;
              end
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end
          default: state_next = S_IDLE;
        endcase
        if (bus.STOP[gi]) begin
          state_next = S_IDLE;
          done_next  = 1'b0;
        end
        pulse_next = (state_next == S_RUN) && (cnt_next < width_sh_next);
      end

      always_ff @(posedge CLK) begin
        if (RST) begin
          state_reg     <= S_IDLE;
          cnt_reg       <= '0;
          burst_cnt_reg <= '0;
          period_sh_reg <= CNT_W'(DEF_PERIOD);
          width_sh_reg  <= CNT_W'(DEF_WIDTH);
          burst_sh_reg  <= '0;
`ifdef PULSE_GEN_PHASE_EN
          phase_sh_reg  <= '0;
`endif
          pulse_reg     <= 1'b0;
          done_reg      <= 1'b0;
        end else begin
          state_reg     <= state_next;
          cnt_reg       <= cnt_next;
          burst_cnt_reg <= burst_cnt_next;
          period_sh_reg <= period_sh_next;
          width_sh_reg  <= width_sh_next;
          burst_sh_reg  <= burst_sh_next;
`ifdef PULSE_GEN_PHASE_EN
          phase_sh_reg  <= phase_sh_next;
`endif
          pulse_reg     <= pulse_next;
          done_reg      <= done_next;
        end
      end

      assign pulse_vec[gi] = pulse_reg;
      assign busy_vec[gi]  = (state_reg != S_IDLE);
      assign done_vec[gi]  = done_reg;
    end
  endgenerate

  assign bus.PULSE = pulse_vec;
  assign bus.BUSY  = busy_vec;
  assign bus.DONE  = done_vec;
endmodule
